// File: rtl/instr_encoder_loader.sv
// LEGv8 field-level encoder and sequential instruction-memory loader; holds the CPU in reset until loaded.
// Optional feature macro: HALT_PAD_EN appends a "B 0" self-loop after the final instruction.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [25:0]       imm,
  input  logic              last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic              cpu_reset
);

  // Handshake: a word transfers on any rising edge where in_valid && in_ready;
  // in_ready depends only on state, and in_valid must hold its fields until taken.

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef HALT_PAD_EN
    S_PAD,
`endif
    S_FULL,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_WORDS - 1);
  localparam logic [31:0]     HALT_WORD = 32'h1400_0000;

  state_t              state, state_nx;
  logic                wr_en_nx, done_nx, err_nx, cpu_reset_nx;
  logic [ADDR_W-1:0]   wr_addr_nx;
  logic [31:0]         wr_data_nx;
  logic [ADDR_W:0]     count_nx;
  logic                enc_bad;
  logic [31:0]         enc_word;
  logic                accept;

  // Range checks treat imm as a 26-bit two's-complement value.
  always_comb begin
    enc_bad  = 1'b0;
    enc_word = 32'h0;
    case (op)
      4'd0: begin
        enc_word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        enc_bad  = !((~|imm[25:8]) || (&imm[25:8]));
      end
      4'd1: begin
        enc_word = {10'b1001000100, imm[11:0], rn, rd};
        enc_bad  = |imm[25:12];
      end
      4'd2: enc_word = {6'b000101, imm[25:0]};
      4'd3: enc_word = {11'b11101011000, rm, 6'b0, rn, rd};
      4'd4: enc_word = {11'b11001010000, rm, 6'b0, rn, rd};
      4'd5: begin
        enc_word = {8'b10110100, imm[18:0], rd};
        enc_bad  = !((~|imm[25:18]) || (&imm[25:18]));
      end
      4'd6: begin
        enc_word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        enc_bad  = !((~|imm[25:8]) || (&imm[25:8]));
      end
      4'd7: enc_word = {11'b10101011000, rm, 6'b0, rn, rd};
      4'd8: begin
        enc_word = {11'b11010011010, 5'b0, imm[5:0], rn, rd};
        enc_bad  = |imm[25:6];
      end
      4'd9: enc_word = {11'b10001010000, rm, 6'b0, rn, rd};
      4'd10: begin
        enc_word = {8'b01010100, imm[18:0], 5'b01011};
        enc_bad  = !((~|imm[25:18]) || (&imm[25:18]));
      end
      default: enc_bad = 1'b1;
    endcase
  end

  assign in_ready = (state == S_LOAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx     = state;
    wr_en_nx     = 1'b0;
    wr_addr_nx   = wr_addr;
    wr_data_nx   = wr_data;
    count_nx     = count;
    done_nx      = done;
    err_nx       = err;
    cpu_reset_nx = cpu_reset;
    case (state)
      S_LOAD: begin
        if (accept) begin
          if (enc_bad) begin
            err_nx   = 1'b1;
            state_nx = S_ERROR;
          end else begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = count[ADDR_W-1:0];
            wr_data_nx = enc_word;
            count_nx   = count + 1'b1;
`ifdef HALT_PAD_EN
            // No room for the pad once the top address is used.
            if (count == LAST_ADDR) begin
              state_nx = S_FULL;
            end else if (last) begin
              state_nx = S_PAD;
            end
`else
            if (last) begin
              done_nx      = 1'b1;
              cpu_reset_nx = 1'b0;
              state_nx     = S_DONE;
            end else if (count == LAST_ADDR) begin
              state_nx = S_FULL;
            end
`endif
          end
        end
      end
`ifdef HALT_PAD_EN
      S_PAD: begin
        wr_en_nx     = 1'b1;
        wr_addr_nx   = count[ADDR_W-1:0];
        wr_data_nx   = HALT_WORD;
        count_nx     = count + 1'b1;
        done_nx      = 1'b1;
        cpu_reset_nx = 1'b0;
        state_nx     = S_DONE;
      end
`endif
      S_FULL: begin
        err_nx   = 1'b1;
        state_nx = S_ERROR;
      end
      default: begin
        if (start) begin
          count_nx     = '0;
          done_nx      = 1'b0;
          err_nx       = 1'b0;
          cpu_reset_nx = 1'b1;
          state_nx     = S_LOAD;
        end
      end
    endcase
  end

  // Reset wins over a same-edge accept, so an in-flight word is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 32'h0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      state     <= state_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      count     <= count_nx;
      done      <= done_nx;
      err       <= err_nx;
      cpu_reset <= cpu_reset_nx;
    end
  end

  logic unused_halt;
  assign unused_halt = ^HALT_WORD;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a full-size loader and a 4-word loader share field inputs.
module tb_instr_encoder_loader;

  logic        clk, reset;
  logic [3:0]  op;
  logic [4:0]  rd, rn, rm;
  logic [25:0] imm;

  logic        start_a, in_valid_a, last_a, in_ready_a, wr_en_a, done_a, err_a, cpu_reset_a;
  logic [9:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [10:0] count_a;

  logic        start_b, in_valid_b, last_b, in_ready_b, wr_en_b, done_b, err_b, cpu_reset_b;
  logic [9:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [10:0] count_b;

  int checks = 0;
  int errors = 0;

  instr_encoder_loader dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .last(last_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .count(count_a),
    .done(done_a), .err(err_a), .cpu_reset(cpu_reset_a)
  );

  instr_encoder_loader #(.ADDR_W(10), .MEM_WORDS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .last(last_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .count(count_b),
    .done(done_b), .err(err_b), .cpu_reset(cpu_reset_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present fields on dut_a; in_valid stays up until the caller drops it
  task automatic drive_a(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                         input logic [4:0] m, input logic [25:0] i, input logic l);
    op = o; rd = d; rn = n; rm = m; imm = i; last_a = l; in_valid_a = 1'b1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_a = 0; in_valid_a = 0; last_a = 0;
    start_b = 0; in_valid_b = 0; last_b = 0;
    op = 0; rd = 0; rn = 0; rm = 0; imm = 0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_wr_addr", wr_addr_a, 0);
    chk("rst_wr_data", wr_data_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_cpu_reset", cpu_reset_a, 1);
    chk("rst_b_cpu_reset", cpu_reset_b, 1);

    // ADDI, B, ADDS(last)
    pulse_start_a();
    chk("start_in_ready", in_ready_a, 1);
    drive_a(4'd1, 5'd1, 5'd31, 5'd0, 26'd5, 1'b0);
    tick(); in_valid_a = 0;
    chk("addi_wr_en", wr_en_a, 1);
    chk("addi_addr", wr_addr_a, 0);
    chk("addi_data", wr_data_a, 32'h910017E1);
    chk("addi_count", count_a, 1);
    tick();
    chk("idle_wr_en", wr_en_a, 0);
    drive_a(4'd2, 5'd0, 5'd0, 5'd0, -26'sd3, 1'b0);
    tick(); in_valid_a = 0;
    chk("b_addr", wr_addr_a, 1);
    chk("b_data", wr_data_a, 32'h17FFFFFD);
    drive_a(4'd7, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1);
    tick(); in_valid_a = 0;
    chk("adds_wr_en", wr_en_a, 1);
    chk("adds_addr", wr_addr_a, 2);
    chk("adds_data", wr_data_a, 32'hAB020023);
`ifdef HALT_PAD_EN
    chk("adds_done_pad", done_a, 0);
    tick();
    chk("pad_wr_en", wr_en_a, 1);
    chk("pad_addr", wr_addr_a, 3);
    chk("pad_data", wr_data_a, 32'h14000000);
    chk("pad_count", count_a, 4);
`else
    chk("adds_count", count_a, 3);
`endif
    chk("load_done", done_a, 1);
    chk("load_cpu_reset", cpu_reset_a, 0);
    tick();
    chk("done_hold", done_a, 1);
    chk("done_wr_en", wr_en_a, 0);

    // restart from DONE, back-to-back words, start ignored in LOAD
    pulse_start_a();
    chk("restart_done", done_a, 0);
    chk("restart_count", count_a, 0);
    chk("restart_cpu_reset", cpu_reset_a, 1);
    chk("restart_in_ready", in_ready_a, 1);
    drive_a(4'd3, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0);
    start_a = 1'b1;
    tick();
    chk("b2b_subs_addr", wr_addr_a, 0);
    chk("b2b_subs_data", wr_data_a, 32'hEB0600A4);
    drive_a(4'd9, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    tick();
    chk("b2b_and_wr_en", wr_en_a, 1);
    chk("b2b_and_addr", wr_addr_a, 1);
    chk("b2b_and_data", wr_data_a, 32'h8A030041);
    start_a = 1'b0;
    drive_a(4'd4, 5'd7, 5'd8, 5'd9, 26'd0, 1'b0);
    tick();
    chk("b2b_eor_addr", wr_addr_a, 2);
    chk("b2b_eor_data", wr_data_a, 32'hCA090107);
    drive_a(4'd8, 5'd2, 5'd3, 5'd0, 26'd4, 1'b0);
    tick();
    chk("lsr_data", wr_data_a, 32'hD3401062);
    drive_a(4'd0, 5'd1, 5'd2, 5'd0, -26'sd8, 1'b0);
    tick();
    chk("ldur_data", wr_data_a, 32'hF85F8041);
    drive_a(4'd6, 5'd3, 5'd4, 5'd0, 26'd16, 1'b0);
    tick();
    chk("stur_data", wr_data_a, 32'hF8010083);
    drive_a(4'd5, 5'd5, 5'd0, 5'd0, -26'sd1, 1'b0);
    tick();
    chk("cbz_data", wr_data_a, 32'hB4FFFFE5);
    drive_a(4'd10, 5'd0, 5'd0, 5'd0, 26'd2, 1'b0);
    tick(); in_valid_a = 0;
    chk("blt_addr", wr_addr_a, 7);
    chk("blt_data", wr_data_a, 32'h5400004B);
    chk("b2b_count", count_a, 8);
    chk("b2b_in_ready", in_ready_a, 1);

    // range boundaries within a load
    drive_a(4'd1, 5'd0, 5'd0, 5'd0, 26'd4095, 1'b0);
    tick(); in_valid_a = 0;
    chk("addi_max_data", wr_data_a, 32'h913FFC00);
    drive_a(4'd0, 5'd0, 5'd0, 5'd0, -26'sd256, 1'b0);
    tick(); in_valid_a = 0;
    chk("ldur_min_data", wr_data_a, 32'hF8500000);

    // bad words
    drive_a(4'd0, 5'd1, 5'd2, 5'd0, 26'd256, 1'b0);
    tick(); in_valid_a = 0;
    chk("ldur256_wr_en", wr_en_a, 0);
    chk("ldur256_err", err_a, 1);
    chk("ldur256_in_ready", in_ready_a, 0);
    chk("ldur256_cpu_reset", cpu_reset_a, 1);
    chk("ldur256_count", count_a, 10);
    pulse_start_a();
    chk("err_cleared", err_a, 0);
    drive_a(4'd12, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    tick(); in_valid_a = 0;
    chk("op12_err", err_a, 1);
    chk("op12_wr_en", wr_en_a, 0);
    pulse_start_a();
    drive_a(4'd1, 5'd0, 5'd0, 5'd0, 26'd4096, 1'b0);
    tick(); in_valid_a = 0;
    chk("addi4096_err", err_a, 1);
    pulse_start_a();
    drive_a(4'd8, 5'd0, 5'd0, 5'd0, 26'd64, 1'b0);
    tick(); in_valid_a = 0;
    chk("lsr64_err", err_a, 1);
    chk("lsr64_count", count_a, 0);

    // reset mid-load, with a word offered on the reset edge
    pulse_start_a();
    drive_a(4'd1, 5'd1, 5'd0, 5'd0, 26'd1, 1'b0);
    tick(); tick();
    chk("mid_count", count_a, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid_a = 0;
    chk("mid_rst_wr_en", wr_en_a, 0);
    chk("mid_rst_count", count_a, 0);
    chk("mid_rst_addr", wr_addr_a, 0);
    chk("mid_rst_in_ready", in_ready_a, 0);
    chk("mid_rst_cpu_reset", cpu_reset_a, 1);
    pulse_start_a();
    drive_a(4'd1, 5'd1, 5'd31, 5'd0, 26'd5, 1'b0);
    tick(); in_valid_a = 0;
    chk("after_rst_addr", wr_addr_a, 0);
    chk("after_rst_data", wr_data_a, 32'h910017E1);

    // small memory: last on the 4th word
    op = 4'd1; rd = 5'd1; rn = 5'd0; rm = 5'd0; imm = 26'd1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    in_valid_b = 1'b1; last_b = 1'b0;
    tick(); tick(); tick();
    last_b = 1'b1;
    tick(); in_valid_b = 0; last_b = 0;
    chk("small_last_wr_en", wr_en_b, 1);
    chk("small_last_addr", wr_addr_b, 3);
    chk("small_last_count", count_b, 4);
`ifdef HALT_PAD_EN
    chk("small_last_done_pad", done_b, 0);
    tick();
    chk("small_last_err_pad", err_b, 1);
    chk("small_last_nopad", wr_en_b, 0);
    chk("small_last_count2", count_b, 4);
`else
    chk("small_last_done", done_b, 1);
    chk("small_last_cpu_reset", cpu_reset_b, 0);
`endif

    // small memory: 4 words without last overflows
    start_b = 1'b1; tick(); start_b = 1'b0;
    in_valid_b = 1'b1;
    tick(); tick(); tick(); tick();
    in_valid_b = 0;
    chk("full_wr_en", wr_en_b, 1);
    chk("full_addr", wr_addr_b, 3);
    chk("full_in_ready", in_ready_b, 0);
    tick();
    chk("full_err", err_b, 1);
    chk("full_count", count_b, 4);
    chk("full_done", done_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
